imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 119 +++++++++++
 tb/tb_imem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: fetch/loader arbiter for a single-port instruction memory; define IMEM_ARB_RR_EN for round-robin ties
module imem_arbiter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic              f_err,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic              l_err,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    input  logic [31:0]       mem_rd,
    output logic [15:0]       stall_cnt
);
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        f_pend_q, f_pend_d, f_bad_q, f_bad_d;
    logic        l_pend_q, l_pend_d, l_bad_q, l_bad_d, l_wr_q, l_wr_d;
    logic [15:0] stall_q, stall_d;
    logic        f_cand, locked, tie, f_win, f_mis, l_mis;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], l_addr[31:ADDR_W+2]};

`ifdef IMEM_ARB_RR_EN
    logic rr_q, rr_d;

    // rr_q set means the loader wins the next tie; only real ARB ties move it
    always_comb begin
        rr_d = (tie && !locked) ? f_win : rr_q;
    end

    // round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
`endif

    // grant selection and memory port drive; a flushed fetch does not compete
    always_comb begin
        f_cand = f_req && !f_flush;
        locked = (state_q == LOCK) && l_lock;
        tie    = f_cand && l_req;
`ifdef IMEM_ARB_RR_EN
        f_win  = tie ? !rr_q : f_cand;
`else
        f_win  = f_cand;
`endif
        f_gnt  = !reset && !locked && f_win;
        l_gnt  = !reset && l_req && !f_gnt;
        f_mis  = f_addr[1:0] != 2'b00;
        l_mis  = l_addr[1:0] != 2'b00;
        mem_en = (f_gnt && !f_mis) || (l_gnt && !l_mis);
        mem_we = l_gnt && !l_mis && l_we;
        mem_a  = l_gnt ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
        mem_d  = l_gnt ? l_wdata : 32'd0;
    end

    // next state: lock persists while l_lock holds, responses follow grants by one cycle
    always_comb begin
        state_d  = (locked || (l_gnt && l_lock)) ? LOCK : ARB;
        f_pend_d = f_gnt;
        f_bad_d  = f_mis;
        l_pend_d = l_gnt;
        l_bad_d  = l_mis;
        l_wr_d   = l_we;
        stall_d  = (f_req && !f_gnt && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    // registered arbitration state, pending responses and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            f_pend_q <= 1'b0;
            f_bad_q  <= 1'b0;
            l_pend_q <= 1'b0;
            l_bad_q  <= 1'b0;
            l_wr_q   <= 1'b0;
            stall_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            f_pend_q <= f_pend_d;
            f_bad_q  <= f_bad_d;
            l_pend_q <= l_pend_d;
            l_bad_q  <= l_bad_d;
            l_wr_q   <= l_wr_d;
            stall_q  <= stall_d;
        end
    end

    // responses: flush drops a due fetch reply, reset drops anything in flight
    always_comb begin
        f_rvalid  = !reset && f_pend_q && !f_flush;
        f_err     = f_rvalid && f_bad_q;
        f_rdata   = (f_rvalid && !f_bad_q) ? mem_rd : 32'd0;
        l_rvalid  = !reset && l_pend_q;
        l_err     = l_rvalid && l_bad_q;
        l_rdata   = (l_rvalid && !l_bad_q && !l_wr_q) ? mem_rd : 32'd0;
        stall_cnt = stall_q;
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter (expected ties follow IMEM_ARB_RR_EN)
module tb_imem_arbiter;
    typedef struct packed {
        logic        v;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk, reset;
    logic        f_req, f_flush, f_gnt, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_a;
    logic [31:0] mem_d, mem_rd;
    logic [15:0] stall_cnt;
    logic [31:0] ram [64];
    rsp_t        fq[$], lq[$];
    rsp_t        ex;
    int          errors = 0, checks = 0;

    imem_arbiter #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_err(f_err), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_rd(mem_rd),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h00500093 : {8'hC3, 8'(i), 16'h1E5A};
    endfunction

    // memory with registered read data, preloaded on reset
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            mem_rd <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_a] <= mem_d;
            else mem_rd <= ram[mem_a];
        end
    end

    task automatic drive(input logic rs, input logic fr, input logic [31:0] fa, input logic ff,
                         input logic lr, input logic lw, input logic ll,
                         input logic [31:0] la, input logic [31:0] ld);
        @(negedge clk);
        reset = rs; f_req = fr; f_addr = fa; f_flush = ff;
        l_req = lr; l_we = lw; l_lock = ll; l_addr = la; l_wdata = ld;
        #1;
    endtask

    task automatic test_reset;
        drive(1, 1, 32'h8, 0, 1, 1, 0, 32'h10, 32'h1);
        checks++;
        if ({f_gnt, l_gnt, mem_en, mem_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt: got %b expected 0000", {f_gnt, l_gnt, mem_en, mem_we});
        end
        drive(1, 1, 32'h8, 0, 1, 0, 0, 32'h10, 0);
        checks++;
        if ({f_rvalid, f_err, l_rvalid, l_err, f_rdata, l_rdata} !== 68'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_out: got fv=%b fe=%b lv=%b le=%b fd=%h ld=%h st=%0d expected all 0",
                               f_rvalid, f_err, l_rvalid, l_err, f_rdata, l_rdata, stall_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 16'd0 || f_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_release: got st=%0d fv=%b lv=%b expected 0 0 0", stall_cnt, f_rvalid, l_rvalid);
        end
        fq.delete(); lq.delete();
    endtask

    task automatic test_lock;
        logic [6:0] fr_t = 7'b0011110, lr_t = 7'b0111111, ll_t = 7'b0001111;
        logic [6:0] fg_t = 7'b0010000, lg_t = 7'b0101111;
        for (int i = 0; i < 7; i++) begin
            drive(0, fr_t[i], 32'h08, 0, lr_t[i], 1, ll_t[i], 32'h20 + 32'(4 * i), 32'(i));
            if (fq.size() != 0) ex = fq.pop_front(); else ex = '0;
            checks++;
            if ({f_rvalid, f_err, f_rdata} !== ex) begin
                errors++; $display("FAIL lock_f_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, f_rvalid, f_err, f_rdata, ex.v, ex.err, ex.data);
            end
            if (lq.size() != 0) ex = lq.pop_front(); else ex = '0;
            checks++;
            if ({l_rvalid, l_err, l_rdata} !== ex) begin
                errors++; $display("FAIL lock_l_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, l_rvalid, l_err, l_rdata, ex.v, ex.err, ex.data);
            end
            checks++;
            if (f_gnt !== fg_t[i] || l_gnt !== lg_t[i]) begin
                errors++; $display("FAIL lock_gnt[%0d]: got f=%b l=%b expected f=%b l=%b", i, f_gnt, l_gnt, fg_t[i], lg_t[i]);
            end
            if (fg_t[i]) fq.push_back({1'b1, 1'b0, 32'h00500093});
            if (lg_t[i]) lq.push_back({1'b1, 1'b0, 32'h0});
            if (i >= 4) begin
                checks++;
                if (stall_cnt !== 16'd3) begin
                    errors++; $display("FAIL lock_stall[%0d]: got %0d expected 3", i, stall_cnt);
                end
            end
        end
    endtask

    task automatic test_fetch_read;
        for (int i = 0; i < 3; i++) begin
            drive(0, i == 0, 32'h8000_0008, 0, i == 1, 0, 0, 32'hFFFF_FF14, 0);
            if (fq.size() != 0) ex = fq.pop_front(); else ex = '0;
            checks++;
            if ({f_rvalid, f_err, f_rdata} !== ex) begin
                errors++; $display("FAIL read_f_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, f_rvalid, f_err, f_rdata, ex.v, ex.err, ex.data);
            end
            if (lq.size() != 0) ex = lq.pop_front(); else ex = '0;
            checks++;
            if ({l_rvalid, l_err, l_rdata} !== ex) begin
                errors++; $display("FAIL read_l_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, l_rvalid, l_err, l_rdata, ex.v, ex.err, ex.data);
            end
            if (i == 0) begin
                checks++;
                if ({f_gnt, l_gnt, mem_en, mem_we} !== 4'b1010 || mem_a !== 6'd2) begin
                    errors++; $display("FAIL read_f_gnt: got gnt/en/we=%b a=%0d expected 1010 a=2", {f_gnt, l_gnt, mem_en, mem_we}, mem_a);
                end
                fq.push_back({1'b1, 1'b0, 32'h00500093});
            end
            if (i == 1) begin
                checks++;
                if ({f_gnt, l_gnt, mem_en, mem_we} !== 4'b0110 || mem_a !== 6'd5) begin
                    errors++; $display("FAIL read_l_gnt: got gnt/en/we=%b a=%0d expected 0110 a=5", {f_gnt, l_gnt, mem_en, mem_we}, mem_a);
                end
                lq.push_back({1'b1, 1'b0, init_word(5)});
            end
        end
    endtask

    task automatic test_write_read;
        for (int i = 0; i < 3; i++) begin
            drive(0, i == 1, 32'h10, 0, i == 0, 1, 0, 32'h10, 32'hDEADBEEF);
            if (fq.size() != 0) ex = fq.pop_front(); else ex = '0;
            checks++;
            if ({f_rvalid, f_err, f_rdata} !== ex) begin
                errors++; $display("FAIL wr_f_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, f_rvalid, f_err, f_rdata, ex.v, ex.err, ex.data);
            end
            if (lq.size() != 0) ex = lq.pop_front(); else ex = '0;
            checks++;
            if ({l_rvalid, l_err, l_rdata} !== ex) begin
                errors++; $display("FAIL wr_l_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, l_rvalid, l_err, l_rdata, ex.v, ex.err, ex.data);
            end
            if (i == 0) begin
                checks++;
                if ({l_gnt, mem_en, mem_we} !== 3'b111 || mem_a !== 6'd4 || mem_d !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL wr_mem: got gnt/en/we=%b a=%0d d=%h expected 111 a=4 d=deadbeef", {l_gnt, mem_en, mem_we}, mem_a, mem_d);
                end
                lq.push_back({1'b1, 1'b0, 32'h0});
            end
            if (i == 1) begin
                checks++;
                if (f_gnt !== 1'b1 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL wr_f_gnt: got gnt=%b we=%b expected 1 0", f_gnt, mem_we);
                end
                fq.push_back({1'b1, 1'b0, 32'hDEADBEEF});
            end
        end
    endtask

    task automatic test_tie;
`ifdef IMEM_ARB_RR_EN
        logic [3:0] fw = 4'b0101;
        logic [15:0] st = 16'd2;
`else
        logic [3:0] fw = 4'b1111;
        logic [15:0] st = 16'd0;
`endif
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, i < 4, 32'h0C, 0, i < 4, 0, 0, 32'h18, 0);
            if (fq.size() != 0) ex = fq.pop_front(); else ex = '0;
            checks++;
            if ({f_rvalid, f_err, f_rdata} !== ex) begin
                errors++; $display("FAIL tie_f_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, f_rvalid, f_err, f_rdata, ex.v, ex.err, ex.data);
            end
            if (lq.size() != 0) ex = lq.pop_front(); else ex = '0;
            checks++;
            if ({l_rvalid, l_err, l_rdata} !== ex) begin
                errors++; $display("FAIL tie_l_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, l_rvalid, l_err, l_rdata, ex.v, ex.err, ex.data);
            end
            if (i < 4) begin
                checks++;
                if (f_gnt !== fw[i] || l_gnt !== !fw[i]) begin
                    errors++; $display("FAIL tie_gnt[%0d]: got f=%b l=%b expected f=%b l=%b", i, f_gnt, l_gnt, fw[i], !fw[i]);
                end
                if (fw[i]) fq.push_back({1'b1, 1'b0, init_word(3)});
                else lq.push_back({1'b1, 1'b0, init_word(6)});
            end else begin
                checks++;
                if (stall_cnt !== st) begin
                    errors++; $display("FAIL tie_stall: got %0d expected %0d", stall_cnt, st);
                end
            end
        end
    endtask

    task automatic test_misaligned_flush;
        logic [4:0] fr_t = 5'b00111, ff_t = 5'b00100, lr_t = 5'b00100;
        logic [4:0] fg_t = 5'b00011, lg_t = 5'b00100, en_t = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            drive(0, fr_t[i], (i == 0) ? 32'h06 : 32'h0C, ff_t[i], lr_t[i], 1, 0, 32'h13, 32'h12345678);
            if (fq.size() != 0) ex = fq.pop_front(); else ex = '0;
            checks++;
            if ({f_rvalid, f_err, f_rdata} !== ex) begin
                errors++; $display("FAIL mis_f_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, f_rvalid, f_err, f_rdata, ex.v, ex.err, ex.data);
            end
            if (lq.size() != 0) ex = lq.pop_front(); else ex = '0;
            checks++;
            if ({l_rvalid, l_err, l_rdata} !== ex) begin
                errors++; $display("FAIL mis_l_rsp[%0d]: got %b/%b/%h expected %b/%b/%h", i, l_rvalid, l_err, l_rdata, ex.v, ex.err, ex.data);
            end
            checks++;
            if (f_gnt !== fg_t[i] || l_gnt !== lg_t[i] || mem_en !== en_t[i] || mem_we !== 1'b0) begin
                errors++; $display("FAIL mis_gnt[%0d]: got f=%b l=%b en=%b we=%b expected %b %b %b 0",
                                   i, f_gnt, l_gnt, mem_en, mem_we, fg_t[i], lg_t[i], en_t[i]);
            end
            if (i == 0) fq.push_back({1'b1, 1'b1, 32'h0});
            if (i == 2) lq.push_back({1'b1, 1'b1, 32'h0});
        end
    endtask

    task automatic test_reset_inflight;
        logic [3:0] rs_t = 4'b0010, fr_t = 4'b0110, lr_t = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive(rs_t[i], fr_t[i], 32'h08, 0, lr_t[i], 0, 1, 32'h08, 0);
            if (fq.size() != 0) ex = fq.pop_front(); else ex = '0;
            checks++;
            if ({f_rvalid, f_err, f_rdata} !== ex || l_rvalid !== 1'b0) begin
                errors++; $display("FAIL rst_rsp[%0d]: got f=%b/%b/%h l=%b expected %b/%b/%h l=0",
                                   i, f_rvalid, f_err, f_rdata, l_rvalid, ex.v, ex.err, ex.data);
            end
            if (i == 1) begin
                checks++;
                if ({f_gnt, l_gnt, mem_en, mem_we} !== 4'b0000) begin
                    errors++; $display("FAIL rst_gnt: got %b expected 0000", {f_gnt, l_gnt, mem_en, mem_we});
                end
            end
            if (i == 2) begin
                checks++;
                if (f_gnt !== 1'b1 || l_gnt !== 1'b0 || stall_cnt !== 16'd0) begin
                    errors++; $display("FAIL rst_arb: got f=%b l=%b st=%0d expected 1 0 0", f_gnt, l_gnt, stall_cnt);
                end
                fq.push_back({1'b1, 1'b0, 32'h00500093});
            end
        end
    endtask

    task automatic test_saturation;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (f_gnt !== 1'b0 || f_rvalid !== 1'b0) begin
            errors++; $display("FAIL sat_flush: got gnt=%b rv=%b expected 0 0", f_gnt, f_rvalid);
        end
        repeat (65535) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_reach: got %h expected ffff", stall_cnt);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff", stall_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; f_req = 0; f_addr = 0; f_flush = 0;
        l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
        test_reset;
        test_lock;
        test_fetch_read;
        test_write_read;
        test_tie;
        test_misaligned_flush;
        test_reset_inflight;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
